// File: rtl/ntt_bram_sched.sv
// ntt_bram_sched: sequencing controller for the 16-bank coefficient BRAM chain
// of the 8-BU NTT core. It runs row load, all butterfly stages (ping-ponging
// between the two address halves) and handshaked result readout.
// Optional feature macro: NTT_SCHED_PERF_EN (busy-cycle performance counter).
module ntt_bram_sched #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_STAGES = 7,
    parameter int BU_LAT     = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic                  ld_valid_i,
    output logic                  ld_ready_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [1:0]            mode_BRAM_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_a_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_b_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_a_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_b_o,
    output logic                  bu_valid_o,
    output logic [3:0]            stage_o,
    output logic [15:0]           perf_cycles_o
);

    localparam int R         = ADDR_WIDTH - 1;
    localparam int ROWS      = 1 << R;
    localparam int HALF      = ROWS / 2;
    localparam int STAGE_CYC = HALF + BU_LAT;
    localparam int KW        = $clog2(STAGE_CYC);

    localparam logic [KW-1:0] K_HALF   = KW'(HALF);
    localparam logic [KW-1:0] K_LAST   = KW'(STAGE_CYC - 1);
    localparam logic [R-1:0]  ROW_LAST = '1;
    localparam logic [3:0]    S_LAST   = 4'(NUM_STAGES - 1);
    localparam logic          RES_HALF = 1'(NUM_STAGES % 2);

    // Encoding doubles as the BRAM chain mode code.
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_LOAD    = 2'b01,
        S_RUN     = 2'b10,
        S_READOUT = 2'b11
    } state_e;

    state_e state_q, state_d;
    logic [R-1:0]  row_q, row_d;
    logic [KW-1:0] k_q, k_d;
    logic [3:0]    s_q, s_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ld_ready_q, ld_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic                  we_q, we_d;
    logic                  bu_valid_q, issue_d;
    logic [ADDR_WIDTH-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic [ADDR_WIDTH-1:0] wr_a_q, wr_a_d, wr_b_q, wr_b_d;

    // Write-back delay line: valid plus full write addresses of each issue.
    logic [BU_LAT-1:0]     pv_q;
    logic [ADDR_WIDTH-1:0] pa_q [BU_LAT];
    logic [ADDR_WIDTH-1:0] pb_q [BU_LAT];

    logic                  hs_ld, hs_out;
    logic [R-2:0]          c_d;
    logic [R-1:0]          mask_d, row_a_d, row_b_d;

    // One-hot mask of the butterfly bit for stage s.
    function automatic logic [R-1:0] bfly_mask(input logic [3:0] s);
        int unsigned b;
        b = int'(R - 1) - (int'(s) % R);
        return R'(1) << b;
    endfunction

    // Insert a zero into c at the butterfly bit position.
    function automatic logic [R-1:0] pair_row_a(input logic [R-2:0] c, input logic [R-1:0] m);
        logic [R-1:0] ce, lo;
        ce = {1'b0, c};
        lo = m - R'(1);
        return ((ce & ~lo) << 1) | (ce & lo);
    endfunction

    // Next-state logic plus next values of every registered output.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        k_d     = k_q;
        s_d     = s_q;
        hs_ld   = (state_q == S_LOAD) && ld_valid_i && ld_ready_q;
        hs_out  = (state_q == S_READOUT) && out_valid_q && out_ready_i;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    row_d   = '0;
                    k_d     = '0;
                    s_d     = '0;
                end
            end
            S_LOAD: begin
                if (hs_ld) begin
                    row_d = row_q + 1'b1;
                    if (row_q == ROW_LAST) begin
                        state_d = S_RUN;
                        k_d     = '0;
                        s_d     = '0;
                    end
                end
            end
            S_RUN: begin
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (s_q == S_LAST) begin
                        state_d = S_READOUT;
                        row_d   = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_READOUT: begin
                if (hs_out) begin
                    row_d = row_q + 1'b1;
                    if (row_q == ROW_LAST) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are computed from next-state values so that the registered
        // copies line up with the state they belong to.
        c_d     = k_d[R-2:0];
        mask_d  = bfly_mask(s_d);
        row_a_d = pair_row_a(c_d, mask_d);
        row_b_d = row_a_d | mask_d;
        issue_d = (state_d == S_RUN) && (k_d < K_HALF);

        rd_a_d = '0;
        rd_b_d = '0;
        if (issue_d) begin
            rd_a_d = {s_d[0], row_a_d};
            rd_b_d = {s_d[0], row_b_d};
        end else if (state_d == S_READOUT) begin
            rd_a_d = {RES_HALF, row_d};
            rd_b_d = {RES_HALF, row_d};
        end

        we_d   = 1'b0;
        wr_a_d = '0;
        wr_b_d = '0;
        if (hs_ld) begin
            we_d   = 1'b1;
            wr_a_d = {1'b0, row_q};
            wr_b_d = {1'b0, row_q};
        end else if (pv_q[BU_LAT-1]) begin
            we_d   = 1'b1;
            wr_a_d = pa_q[BU_LAT-1];
            wr_b_d = pb_q[BU_LAT-1];
        end

        ld_ready_d  = (state_d == S_LOAD);
        out_valid_d = (state_q == S_READOUT) && (state_d == S_READOUT) && !hs_out;
        done_d      = hs_out && (row_q == ROW_LAST);
        busy_d      = (state_d != S_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            k_q         <= '0;
            s_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ld_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            we_q        <= 1'b0;
            bu_valid_q  <= 1'b0;
            rd_a_q      <= '0;
            rd_b_q      <= '0;
            wr_a_q      <= '0;
            wr_b_q      <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            k_q         <= k_d;
            s_q         <= s_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ld_ready_q  <= ld_ready_d;
            out_valid_q <= out_valid_d;
            we_q        <= we_d;
            bu_valid_q  <= issue_d;
            rd_a_q      <= rd_a_d;
            rd_b_q      <= rd_b_d;
            wr_a_q      <= wr_a_d;
            wr_b_q      <= wr_b_d;
        end
    end

    // Delay line: stage 0 mirrors the issue registers, so the tap at
    // BU_LAT-1 drives we_o exactly BU_LAT cycles after bu_valid_o.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pv_q <= '0;
            for (int unsigned i = 0; i < BU_LAT; i++) begin
                pa_q[i] <= '0;
                pb_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= issue_d;
            pa_q[0] <= {~s_d[0], row_a_d};
            pb_q[0] <= {~s_d[0], row_b_d};
            for (int unsigned i = 1; i < BU_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pa_q[i] <= pa_q[i-1];
                pb_q[i] <= pb_q[i-1];
            end
        end
    end

`ifdef NTT_SCHED_PERF_EN
    logic [15:0] perf_q;

    // Busy-cycle counter: clears on start, saturates, holds while idle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_q <= '0;
        end else if ((state_q == S_IDLE) && start_i) begin
            perf_q <= '0;
        end else if ((state_q != S_IDLE) && (perf_q != '1)) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign perf_cycles_o = perf_q;
`else
    assign perf_cycles_o = '0;
`endif

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign ld_ready_o  = ld_ready_q;
    assign out_valid_o = out_valid_q;
    assign mode_BRAM_o = state_q;
    assign we_o        = we_q;
    assign rd_addr_a_o = rd_a_q;
    assign rd_addr_b_o = rd_b_q;
    assign wr_addr_a_o = wr_a_q;
    assign wr_addr_b_o = wr_b_q;
    assign bu_valid_o  = bu_valid_q;
    assign stage_o     = s_q;

endmodule

// File: tb/tb_ntt_bram_sched.sv
// Testbench for ntt_bram_sched (default parameters: 16 rows, 7 stages,
// BU_LAT 4). Expected write-backs and readout addresses go through queues.
module tb_ntt_bram_sched;

    localparam int AW     = 5;
    localparam int R      = AW - 1;
    localparam int ROWS   = 1 << R;
    localparam int HALFR  = ROWS / 2;
    localparam int LAT    = 4;
    localparam int STAGES = 7;
    localparam int SCYC   = HALFR + LAT;

    logic          clk = 1'b0;
    logic          rst_i, start_i, ld_valid_i, out_ready_i;
    logic          busy_o, done_o, ld_ready_o, out_valid_o, we_o, bu_valid_o;
    logic [1:0]    mode_BRAM_o;
    logic [AW-1:0] rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
    logic [3:0]    stage_o;
    logic [15:0]   perf_cycles_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int due;
        int wa;
        int wb;
    } wr_t;

    wr_t wq[$];
    int  lq[$];

    always #5 clk = ~clk;

    ntt_bram_sched #(.ADDR_WIDTH(AW), .NUM_STAGES(STAGES), .BU_LAT(LAT)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .ld_valid_i   (ld_valid_i),
        .ld_ready_o   (ld_ready_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .mode_BRAM_o  (mode_BRAM_o),
        .we_o         (we_o),
        .rd_addr_a_o  (rd_addr_a_o),
        .rd_addr_b_o  (rd_addr_b_o),
        .wr_addr_a_o  (wr_addr_a_o),
        .wr_addr_b_o  (wr_addr_b_o),
        .bu_valid_o   (bu_valid_o),
        .stage_o      (stage_o),
        .perf_cycles_o(perf_cycles_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int bbit(input int s);
        return R - 1 - (s % R);
    endfunction

    function automatic int exp_row_a(input int c, input int s);
        int b;
        b = bbit(s);
        return ((c >> b) << (b + 1)) | (c & ((1 << b) - 1));
    endfunction

    function automatic int exp_row_b(input int c, input int s);
        return exp_row_a(c, s) | (1 << bbit(s));
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   32'(busy_o), 0);
        chk({tag, "_done"},   32'(done_o), 0);
        chk({tag, "_ldrdy"},  32'(ld_ready_o), 0);
        chk({tag, "_oval"},   32'(out_valid_o), 0);
        chk({tag, "_we"},     32'(we_o), 0);
        chk({tag, "_buv"},    32'(bu_valid_o), 0);
        chk({tag, "_mode"},   32'(mode_BRAM_o), 0);
        chk({tag, "_rda"},    32'(rd_addr_a_o), 0);
        chk({tag, "_rdb"},    32'(rd_addr_b_o), 0);
        chk({tag, "_wra"},    32'(wr_addr_a_o), 0);
        chk({tag, "_wrb"},    32'(wr_addr_b_o), 0);
        chk({tag, "_stage"},  32'(stage_o), 0);
        chk({tag, "_perf"},   32'(perf_cycles_o), 0);
    endtask

    // Called at a negedge with the DUT idle; returns at the first RUN cycle.
    task automatic do_load();
        int e;
        start_i    = 1'b1;
        ld_valid_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("ld_mode", 32'(mode_BRAM_o), 1);
        chk("ld_ready", 32'(ld_ready_o), 1);
        chk("ld_busy", 32'(busy_o), 1);
        chk("idle_beat_ignored", 32'(we_o), 0);
        for (int i = 0; i < ROWS; i++) begin
            lq.push_back(i);
            @(negedge clk);
            if (we_o) begin
                e = lq.pop_front();
                chk("ld_wra", 32'(wr_addr_a_o), e);
                chk("ld_wrb", 32'(wr_addr_b_o), e);
            end else begin
                chk("ld_we", 32'(we_o), 1);
                lq.delete();
            end
        end
        chk("ld_to_run_mode", 32'(mode_BRAM_o), 2);
        chk("ld_ready_drop", 32'(ld_ready_o), 0);
    endtask

    // Steps RUN cycle by cycle; abort_cyc >= 0 pulls reset at that cycle.
    task automatic do_run(input int abort_cyc);
        int  s, k, ra, rb;
        wr_t w;
        wq.delete();
        for (int cyc = 0; cyc < STAGES * SCYC; cyc++) begin
            s = cyc / SCYC;
            k = cyc % SCYC;
            if (cyc == abort_cyc) begin
                rst_i = 1'b0;
                #1;
                chk_all_zero("rst_mid");
                repeat (2) @(negedge clk);
                rst_i = 1'b1;
                for (int j = 0; j < 20; j++) begin
                    @(negedge clk);
                    chk("post_rst_we", 32'(we_o), 0);
                    chk("post_rst_busy", 32'(busy_o), 0);
                end
                return;
            end
            chk("run_mode", 32'(mode_BRAM_o), 2);
            chk("run_stage", 32'(stage_o), s);
            chk("run_buv", 32'(bu_valid_o), (k < HALFR) ? 1 : 0);
            if (k < HALFR) begin
                ra = exp_row_a(k, s);
                rb = exp_row_b(k, s);
                chk("run_rda", 32'(rd_addr_a_o), (s % 2) * ROWS + ra);
                chk("run_rdb", 32'(rd_addr_b_o), (s % 2) * ROWS + rb);
                wq.push_back('{due: cyc + LAT, wa: ((s + 1) % 2) * ROWS + ra,
                               wb: ((s + 1) % 2) * ROWS + rb});
            end
            if (cyc == 3) begin
                chk("s0c3_rda", 32'(rd_addr_a_o), 3);
                chk("s0c3_rdb", 32'(rd_addr_b_o), 11);
            end
            if (cyc == 7) begin
                chk("s0c3_wra", 32'(wr_addr_a_o), 19);
                chk("s0c3_wrb", 32'(wr_addr_b_o), 27);
            end
            if (cyc == SCYC + 5) begin
                chk("s1c5_rda", 32'(rd_addr_a_o), 25);
                chk("s1c5_rdb", 32'(rd_addr_b_o), 29);
            end
            if (cyc == SCYC + 5 + LAT) begin
                chk("s1c5_wra", 32'(wr_addr_a_o), 9);
                chk("s1c5_wrb", 32'(wr_addr_b_o), 13);
            end
            if (wq.size() > 0 && wq[0].due == cyc) begin
                w = wq.pop_front();
                chk("run_we", 32'(we_o), 1);
                chk("run_wra", 32'(wr_addr_a_o), w.wa);
                chk("run_wrb", 32'(wr_addr_b_o), w.wb);
            end else if (cyc > 0) begin
                chk("run_we_quiet", 32'(we_o), 0);
            end
            @(negedge clk);
        end
    endtask

    // Called at the first READOUT cycle; stalls row 0 for five cycles.
    task automatic do_readout();
        int e;
        ld_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        chk("ro_mode", 32'(mode_BRAM_o), 3);
        chk("ro_we_quiet", 32'(we_o), 0);
        for (int r = 0; r < ROWS; r++) begin
            lq.push_back(ROWS + r);
            chk("ro_gap_valid", 32'(out_valid_o), 0);
            chk("ro_gap_addr", 32'(rd_addr_a_o), ROWS + r);
            @(negedge clk);
            if (r == 0) begin
                for (int j = 0; j < 5; j++) begin
                    chk("bp_valid", 32'(out_valid_o), 1);
                    chk("bp_addr", 32'(rd_addr_a_o), ROWS);
                    @(negedge clk);
                end
            end
            out_ready_i = 1'b1;
            e = lq.pop_front();
            chk("ro_valid", 32'(out_valid_o), 1);
            chk("ro_rda", 32'(rd_addr_a_o), e);
            chk("ro_rdb", 32'(rd_addr_b_o), e);
            chk("ro_done_early", 32'(done_o), 0);
            @(negedge clk);
        end
        out_ready_i = 1'b0;
        chk("done_pulse", 32'(done_o), 1);
        chk("done_busy", 32'(busy_o), 0);
        chk("done_mode", 32'(mode_BRAM_o), 0);
        chk("done_oval", 32'(out_valid_o), 0);
`ifdef NTT_SCHED_PERF_EN
        chk("perf", 32'(perf_cycles_o), ROWS + STAGES * SCYC + 2 * ROWS + 5);
`else
        chk("perf", 32'(perf_cycles_o), 0);
`endif
        @(negedge clk);
        chk("done_single", 32'(done_o), 0);
`ifdef NTT_SCHED_PERF_EN
        chk("perf_hold", 32'(perf_cycles_o), ROWS + STAGES * SCYC + 2 * ROWS + 5);
`else
        chk("perf_hold", 32'(perf_cycles_o), 0);
`endif
    endtask

    initial begin
        rst_i       = 1'b0;
        start_i     = 1'b0;
        ld_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_i = 1'b1;
        @(negedge clk);

        // Aborted transform: reset in stage 2 with write-backs in flight.
        do_load();
        do_run(2 * SCYC + 6);

        // Full transform after the abort; out_ready_i high during RUN is ignored.
        do_load();
        out_ready_i = 1'b1;
        do_run(-1);
        do_readout();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_bram_sched.md
# ntt_bram_sched

Sequencing controller for the 16-bank (8 butterflies × A/B) coefficient BRAM chain of the 8-BU NTT core. It runs each transform end to end: it accepts row loads from the host and steps the butterfly datapath through all NTT stages, ping-ponging between the two address halves of the banks. It then streams result rows back out under a valid/ready handshake. It drives the chain's mode, write-enable and A/B read/write addresses, and tells the butterfly array when its inputs are valid.

## Interface
- `ADDR_WIDTH`, 5: bank address width. MSB selects the ping/pong half; the low `ADDR_WIDTH-1` bits are the row.
- `NUM_STAGES`, 7: NTT stages per transform, in the range 1..15.
- `BU_LAT`, 4: cycles from a read-address issue to the matching butterfly write-back, at least 1.

Ports:
- `clk_i` in 1: clock; all logic is rising-edge.
- `rst_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: begin a transform. Sampled only in IDLE; ignored in every other state.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse when the last result row is accepted.
- `ld_valid_i` in 1, `ld_ready_o` out 1: row-load handshake.
- `out_valid_o` out 1, `out_ready_i` in 1: result-row handshake.
- `mode_BRAM_o` out 2: 00 idle, 01 load, 10 compute, 11 readout.
- `we_o` out 1: chain write enable.
- `rd_addr_a_o`, `rd_addr_b_o` out `ADDR_WIDTH`: read addresses broadcast to all A banks and all B banks.
- `wr_addr_a_o`, `wr_addr_b_o` out `ADDR_WIDTH`: write addresses.
- `bu_valid_o` out 1: a butterfly read is issued this cycle.
- `stage_o` out 4: current stage index, used for twiddle selection.
- `perf_cycles_o` out 16: see Configuration.

## Operation
Definitions:
- `R = ADDR_WIDTH-1`, `ROWS = 2^R`.
- Per stage `s`, the butterfly bit is `b = R-1-(s mod R)`.
- For pair counter `c` in 0..ROWS/2-1: row_a = c with a 0 inserted at bit `b`; row_b = row_a | 2^b.

FSM states and transitions:
- **IDLE**
  - `start_i` moves the FSM to LOAD and clears the row counter.
- **LOAD**
  - `ld_ready_o` = 1.
  - On each `ld_valid_i & ld_ready_o`: `we_o` = 1 and `wr_addr_a_o` = `wr_addr_b_o` = {0, row}; row then increments.
  - After the ROWS-th accepted beat, go to RUN with `s` = 0 and `c` = 0.
- **RUN**, per stage:
  - Issue cycles 0..ROWS/2-1: `bu_valid_o` = 1, `rd_addr_a_o` = {s[0], row_a}, `rd_addr_b_o` = {s[0], row_b}.
  - A `BU_LAT`-deep shift register carries {valid, row_a, row_b}. On delayed valid: `we_o` = 1, `wr_addr_a_o` = {~s[0], row_a}, `wr_addr_b_o` = {~s[0], row_b}.
  - The stage lasts ROWS/2 + `BU_LAT` cycles, so the last write lands before the next stage's first read.
  - After stage `NUM_STAGES-1`, go to READOUT.
- **READOUT**
  - Results live in half `NUM_STAGES[0]`.
  - `rd_addr_a_o` = `rd_addr_b_o` = {half, row}, held constant while the row is pending.
  - `out_valid_o` rises the cycle after the address changes, covering the 1-cycle BRAM read latency.
  - On handshake: row increments and `out_valid_o` drops for exactly one cycle.
  - After the last row's handshake: `done_o` pulse, then return to IDLE.

Boundary rules:
- `rst_i` low at any time, including mid-stage with writes in flight: FSM returns to IDLE and the delay line is flushed. No write is issued after reset.
- `ld_valid_i` outside LOAD is ignored.
- `out_ready_i` outside READOUT is ignored.
- Row and `c` counters wrap only on a state or stage change, never silently.

## Timing
- Reset values: `busy_o`, `done_o`, `ld_ready_o`, `out_valid_o`, `we_o`, `bu_valid_o` = 0. `mode_BRAM_o` = 00. All addresses, `stage_o` and `perf_cycles_o` = 0.
- All outputs are registered.
- `start_i` sampled high in cycle T gives `mode_BRAM_o` = 01 and `ld_ready_o` = 1 in T+1.
- RUN begins the cycle after the last load beat and lasts `NUM_STAGES*(ROWS/2+BU_LAT)` cycles; default 7×12 = 84.
- Readout takes at least 2 cycles per row.
- `mode_BRAM_o` changes on the same edge as the state.

## Configuration
- `NTT_SCHED_PERF_EN` defined:
  - `perf_cycles_o` clears on start and counts every busy cycle, saturating at 0xFFFF.
  - It holds its value after `done_o` until the next start.
- Undefined: `perf_cycles_o` is constant 0 and no counter logic is generated.

## Test plan
- **Reset mid-RUN.** Assert `rst_i` low during stage 2 with writes in flight. Outputs must take their reset values immediately, with no `we_o` after release, and `start_i` must then work normally.
- **Load.** Present 16 back-to-back load beats. Require `we_o` on each beat with `wr_addr_a_o` = 0..15, then `mode_BRAM_o` = 10 on the next cycle.
- **Stage 0, c = 3.** `rd_addr_a_o` = 3 and `rd_addr_b_o` = 11. Four cycles later: `we_o` = 1, `wr_addr_a_o` = 19, `wr_addr_b_o` = 27.
- **Stage 1, c = 5.** `rd_addr_a_o` = 25 and `rd_addr_b_o` = 29. The writes then go to 9 and 13.
- **Readout with backpressure.** Hold `out_ready_i` low for 5 cycles. Address 16 and `out_valid_o` must stay stable. After 16 handshakes, require a single `done_o` pulse and `busy_o` = 0 on the next cycle.
- **Perf counter** (with `NTT_SCHED_PERF_EN`). With no stalls, `perf_cycles_o` equals 16 + 84 + 2×16 = 132, ±1 for the IDLE→LOAD edge as measured by the bench.
